gpio_multi_delayed_trigger: RTL and testbench
=============================================

Name: gpio_multi_delayed_trigger

Overview:
Multi-channel successor to the single-channel GPIO delayed trigger. An arm/trigger state machine waits for a selectable, edge-qualified GPIO input or a soft trigger. On that event it snapshots per-channel delay/width settings and runs a shared cycle counter. Each channel produces a delayed level trigger and a programmable-width pulse, and the pulses drive the GPIO output pins. It sits between the GPIO header and the acquisition/DAC trigger inputs, under AXI-register configuration.

Parameters:
GPIO_DATA_WIDTH, 8, total gpio_data pins.
GPIO_INPUT_WIDTH, 4, low pins used as inputs (tristated); remaining pins are outputs.
CHANNELS, 4, number of delay/pulse channels; must be <= GPIO_DATA_WIDTH-GPIO_INPUT_WIDTH.
CNT_WIDTH, 32, width of counter, delay and width fields.

Ports:
aclk  in  1  clock
aresetn  in  1  reset; synchronous, active-low; clock aclk
gpio_data  inout  GPIO_DATA_WIDTH  pins [GPIO_INPUT_WIDTH-1:0] input-only; pin GPIO_INPUT_WIDTH+j driven by pulse[j] for j<CHANNELS, else driven 0
arm  in  1  level; 1 = enable arming
auto_rearm  in  1  1 = return to ARMED after run; 0 = stop in DONE
soft_trig  in  1  software trigger, level-sampled
trig_sel  in  clog2(GPIO_INPUT_WIDTH) (min 1)  input pin used as hardware trigger
edge_pol  in  1  1 = rising edge, 0 = falling edge
delay  in  CHANNELS*CNT_WIDTH  per-channel delay in cycles, channel j at [j*CNT_WIDTH +: CNT_WIDTH]
width  in  CHANNELS*CNT_WIDTH  per-channel pulse width in cycles; 0 = no pulse
armed  out  1  state==ARMED
instant_trigger  out  1  state==RUNNING
trigger  out  CHANNELS  per-channel delayed level trigger
pulse  out  CHANNELS  per-channel pulse (also on GPIO)
trig_count  out  32  accepted trigger events, wraps at 2^32

Behaviour:
- Input path: all input pins go through a 2-flop synchroniser plus one history flop. hw_edge = (sync1^sync2) & (sync1==edge_pol) on pin trig_sel.
- Event E at cycle T: (hw_edge | soft_trig) while state==ARMED. E in any other state is ignored and not counted.
- States: IDLE, ARMED, RUNNING, DONE. Registered state; 2-bit encoding.
- IDLE -> ARMED when arm=1.
- ARMED -> IDLE when arm=0. ARMED -> RUNNING on E; arm=0 has priority over E in the same cycle.
- On E: cnt<=0, delay/width snapshotted into internal regs, trig_count+=1.
- RUNNING: cnt increments each cycle and saturates at all-ones.
  - arm=0 aborts to IDLE next cycle; trigger/pulse clear with the state.
  - When all channels are done, go to ARMED if auto_rearm=1, else DONE.
  - Channel j is done when cnt >= d_j+w_j, with the sum computed in CNT_WIDTH+1 bits so it cannot overflow.
- DONE -> IDLE when arm=0. Re-arm requires arm to toggle low then high.
- Outputs are decoded combinationally from registered state, cnt and snapshots:
  - trigger[j] = (RUNNING|DONE) & cnt>=d_j. In DONE it is held high via a per-channel sticky flag; the flag clears on entering ARMED or IDLE.
  - pulse[j] = RUNNING & d_j<=cnt<d_j+w_j.
- Latency: instant_trigger rises at T+1 with cnt=0. trigger[j] rises at T+1+d_j. pulse[j] is high for exactly w_j cycles starting at T+1+d_j.
- Config inputs may change at any time; only the snapshot taken at E is used during a run.
- Reset values: state=IDLE, cnt=0, snapshots=0, trig_count=0, sticky flags=0. All outputs 0; GPIO output pins driven 0.

Test Plan:
1. arm=1, edge_pol=1, trig_sel=2, delay0=5, width0=3; pin2 rises at cycle C -> event at C+2, instant_trigger at C+3, trigger[0] at C+8, pulse[0] high for C+8..C+10, trig_count=1, final state DONE.
2. Four channels with delays 0,1,10,100 and widths 1,0,4,2; soft_trig pulse -> pulse[1] never asserts. Each other pulse appears on GPIO pin 4+j with exactly its width. RUNNING ends after the cycle where cnt=101.
3. auto_rearm=1, second soft_trig while RUNNING -> ignored, trig_count stays 1. Third soft_trig after return to ARMED -> trig_count=2 and the sequence repeats.
4. arm=0 mid-run at cnt=3 with delay=10 -> IDLE next cycle, trigger/pulse stay 0. arm=1 plus edge -> new run with cnt starting from 0.
5. edge_pol=0, pin held high then falling -> triggers. Rising edge or glitch on a non-selected pin -> no event.
6. delay=all-ones, width=2 -> no overflow; cnt saturates and the run ends. aresetn=0 mid-run -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/gpio_multi_delayed_trigger.sv
// gpio_multi_delayed_trigger: edge- or soft-triggered multi-channel delayed trigger and pulse generator driving GPIO outputs
module gpio_multi_delayed_trigger #(
  parameter int GPIO_DATA_WIDTH = 8,
  parameter int GPIO_INPUT_WIDTH = 4,
  parameter int CHANNELS = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  inout  wire  [GPIO_DATA_WIDTH-1:0]        gpio_data,
  input  logic                              arm,
  input  logic                              auto_rearm,
  input  logic                              soft_trig,
  input  logic [(GPIO_INPUT_WIDTH > 1 ? $clog2(GPIO_INPUT_WIDTH) : 1)-1:0] trig_sel,
  input  logic                              edge_pol,
  input  logic [CHANNELS*CNT_WIDTH-1:0]     delay,
  input  logic [CHANNELS*CNT_WIDTH-1:0]     width,
  output logic                              armed,
  output logic                              instant_trigger,
  output logic [CHANNELS-1:0]               trigger,
  output logic [CHANNELS-1:0]               pulse,
  output logic [31:0]                       trig_count
);
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, RUNNING = 2'd2, DONE = 2'd3;
  localparam logic [CNT_WIDTH:0] ONE = 1;
  logic [1:0] state, state_nx;
  logic [GPIO_INPUT_WIDTH-1:0] meta, sync1, sync2;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH:0] cnt_nx;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] d_q, w_q;
  logic [CHANNELS-1:0][CNT_WIDTH:0] stop;
  logic [CHANNELS-1:0] sticky, reached, ch_done;
  logic [GPIO_DATA_WIDTH-GPIO_INPUT_WIDTH-1:0] out_pins;
  logic hw_edge, accept;
  assign hw_edge = (sync1[trig_sel] ^ sync2[trig_sel]) && (sync1[trig_sel] == edge_pol);
  assign accept = state == ARMED && arm && (hw_edge || soft_trig);
  assign cnt_nx = {1'b0, cnt} + ONE;
  assign armed = state == ARMED;
  assign instant_trigger = state == RUNNING;
  assign gpio_data = {out_pins, {GPIO_INPUT_WIDTH{1'bz}}};
  // a run ends once every channel will have finished by the next cycle, or the counter can no longer advance
  assign state_nx = !arm ? IDLE :
                    state == IDLE ? ARMED :
                    state == ARMED ? (accept ? RUNNING : ARMED) :
                    state == RUNNING ? (&ch_done ? (auto_rearm ? ARMED : DONE) : RUNNING) : DONE;
  always_comb begin
    stop = '0;
    reached = '0;
    trigger = '0;
    pulse = '0;
    ch_done = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      stop[j] = {1'b0, d_q[j]} + {1'b0, w_q[j]};
      reached[j] = cnt_nx >= {1'b0, d_q[j]};
      trigger[j] = (state == RUNNING && cnt >= d_q[j]) || (state == DONE && sticky[j]);
      pulse[j] = state == RUNNING && cnt >= d_q[j] && {1'b0, cnt} < stop[j];
      ch_done[j] = cnt_nx >= stop[j] || &cnt;
    end
  end
  always_comb begin
    out_pins = '0;
    out_pins[CHANNELS-1:0] = pulse;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      meta <= '0;
      sync1 <= '0;
      sync2 <= '0;
      cnt <= '0;
      d_q <= '0;
      w_q <= '0;
      sticky <= '0;
      trig_count <= '0;
    end else begin
      state <= state_nx;
      meta <= gpio_data[GPIO_INPUT_WIDTH-1:0];
      sync1 <= meta;
      sync2 <= sync1;
      sticky <= state_nx != DONE ? '0 : state == DONE ? sticky : reached;
      if (accept) begin
        cnt <= '0;
        d_q <= delay;
        w_q <= width;
        trig_count <= trig_count + 32'd1;
      end else if (state == RUNNING && !(&cnt)) begin
        cnt <= cnt_nx[CNT_WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_gpio_multi_delayed_trigger.sv
// tb_gpio_multi_delayed_trigger: scoreboard bench; the monitor summarises each run and each probe, then compares against queued expectations
module tb_gpio_multi_delayed_trigger;
  localparam logic [15:0] N = 16'hFFFF;
  typedef struct packed {
    logic run;
    logic [15:0] lat, len;
    logic [3:0][15:0] tr, ps, pw;
    logic [31:0] tc;
    logic [4:0] after;
    logic [13:0] stat;
  } rec_t;
  logic clk = 0, aresetn = 0, arm = 0, auto_rearm = 0, soft_trig = 0, edge_pol = 1, probe = 0;
  logic [1:0] trig_sel = 2;
  logic [31:0] delay = 0, width = 0;
  logic [3:0] pins = 0;
  wire [7:0] gpio;
  logic armed, instant_trigger;
  logic [3:0] trigger, pulse;
  logic [31:0] trig_count;
  int cyc = 0, mark = 0, vectors = 0, miscompares = 0;
  rec_t exp_q[$];
  string name_q[$];
  assign gpio[3:0] = pins;
  gpio_multi_delayed_trigger #(.GPIO_DATA_WIDTH(8), .GPIO_INPUT_WIDTH(4), .CHANNELS(4), .CNT_WIDTH(8)) dut (
    .aclk(clk), .aresetn(aresetn), .gpio_data(gpio), .arm(arm), .auto_rearm(auto_rearm),
    .soft_trig(soft_trig), .trig_sel(trig_sel), .edge_pol(edge_pol), .delay(delay), .width(width),
    .armed(armed), .instant_trigger(instant_trigger), .trigger(trigger), .pulse(pulse), .trig_count(trig_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  function automatic rec_t run_rec(int lat, int len, logic [3:0][15:0] tr, logic [3:0][15:0] ps,
                                   logic [3:0][15:0] pw, int tc, logic [4:0] after);
    rec_t r = '0;
    r.run = 1;
    r.lat = 16'(lat);
    r.len = 16'(len);
    r.tr = tr;
    r.ps = ps;
    r.pw = pw;
    r.tc = 32'(tc);
    r.after = after;
    return r;
  endfunction
  function automatic rec_t stat_rec(logic [13:0] st, int tc);
    rec_t r = '0;
    r.stat = st;
    r.tc = 32'(tc);
    return r;
  endfunction
  task automatic check(input rec_t got);
    rec_t e;
    string n;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected record got=%h", got);
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s got=%h exp=%h", n, got, e);
      end
    end
  endtask
  initial begin
    rec_t r;
    int start = 0;
    logic inst_q = 0;
    logic [3:0][15:0] tr = '0, ps = '0, pw = '0;
    forever begin
      @(negedge clk);
      if (instant_trigger && !inst_q) begin
        start = cyc;
        tr = {4{N}};
        ps = {4{N}};
        pw = '0;
      end
      if (instant_trigger)
        for (int j = 0; j < 4; j++) begin
          if (trigger[j] && tr[j] == N) tr[j] = 16'(cyc - start);
          if (gpio[4+j]) begin
            pw[j] = pw[j] + 16'd1;
            if (ps[j] == N) ps[j] = 16'(cyc - start);
          end
        end
      if (!instant_trigger && inst_q)
        check(run_rec(start - mark, cyc - start, tr, ps, pw, int'(trig_count), {armed, trigger}));
      if (probe) check(stat_rec({armed, instant_trigger, trigger, pulse, gpio[7:4]}, int'(trig_count)));
      inst_q = instant_trigger;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input string n, input rec_t r);
    exp_q.push_back(r);
    name_q.push_back(n);
  endtask
  task automatic probe_chk(input string n, input logic [13:0] st, input int tc);
    push(n, stat_rec(st, tc));
    probe = 1;
    tick(1);
    probe = 0;
  endtask
  task automatic fire_soft();
    soft_trig = 1;
    mark = cyc;
    tick(1);
    soft_trig = 0;
  endtask
  initial begin
    tick(3);
    probe_chk("reset", 14'h0, 0);
    aresetn = 1;
    tick(2);
    // rising edge on pin 2 with a single configured channel
    delay = {8'd0, 8'd0, 8'd0, 8'd5};
    width = {8'd0, 8'd0, 8'd0, 8'd3};
    arm = 1;
    tick(4);
    push("t1_run", run_rec(3, 8, {16'd0, 16'd0, 16'd0, 16'd5}, {N, N, N, 16'd5}, {16'd0, 16'd0, 16'd0, 16'd3}, 1, 5'b01111));
    pins[2] = 1;
    mark = cyc;
    tick(20);
    probe_chk("t1_done", {2'b00, 4'hF, 8'h00}, 1);
    arm = 0;
    tick(2);
    probe_chk("t1_idle", 14'h0, 1);
    // four channels, one with zero width
    delay = {8'd100, 8'd10, 8'd1, 8'd0};
    width = {8'd2, 8'd4, 8'd0, 8'd1};
    arm = 1;
    tick(2);
    push("t2_run", run_rec(1, 102, {16'd100, 16'd10, 16'd1, 16'd0}, {16'd100, 16'd10, N, 16'd0}, {16'd2, 16'd4, 16'd0, 16'd1}, 2, 5'b01111));
    fire_soft();
    tick(110);
    // auto re-arm, retrigger during a run is ignored
    arm = 0;
    tick(2);
    auto_rearm = 1;
    delay = {8'd0, 8'd0, 8'd0, 8'd3};
    width = {8'd0, 8'd0, 8'd0, 8'd2};
    arm = 1;
    tick(2);
    push("t3_run1", run_rec(1, 5, {16'd0, 16'd0, 16'd0, 16'd3}, {N, N, N, 16'd3}, {16'd0, 16'd0, 16'd0, 16'd2}, 3, 5'b10000));
    fire_soft();
    tick(1);
    soft_trig = 1;
    tick(1);
    soft_trig = 0;
    tick(8);
    probe_chk("t3_armed", {2'b10, 12'h000}, 3);
    push("t3_run2", run_rec(1, 5, {16'd0, 16'd0, 16'd0, 16'd3}, {N, N, N, 16'd3}, {16'd0, 16'd0, 16'd0, 16'd2}, 4, 5'b10000));
    fire_soft();
    tick(10);
    // abort at cnt=3, then a fresh edge-triggered run
    auto_rearm = 0;
    delay = {4{8'd10}};
    width = {4{8'd2}};
    push("t4_abort", run_rec(1, 4, {4{N}}, {4{N}}, '0, 5, 5'b00000));
    fire_soft();
    tick(3);
    arm = 0;
    tick(2);
    probe_chk("t4_idle", 14'h0, 5);
    pins[2] = 0;
    tick(4);
    arm = 1;
    tick(3);
    push("t4_rerun", run_rec(3, 12, {4{16'd10}}, {4{16'd10}}, {4{16'd2}}, 6, 5'b01111));
    pins[2] = 1;
    mark = cyc;
    tick(20);
    // falling-edge polarity; rising edge and other pins must not fire
    arm = 0;
    tick(2);
    edge_pol = 0;
    delay = {8'd0, 8'd0, 8'd0, 8'd2};
    width = {8'd0, 8'd0, 8'd0, 8'd1};
    pins[2] = 0;
    tick(4);
    arm = 1;
    tick(3);
    pins[2] = 1;
    tick(1);
    pins[1] = 1;
    tick(1);
    pins[1] = 0;
    pins[3] = 1;
    tick(6);
    probe_chk("t5_no_event", {2'b10, 12'h000}, 6);
    push("t5_fall", run_rec(3, 3, {16'd0, 16'd0, 16'd0, 16'd2}, {N, N, N, 16'd2}, {16'd0, 16'd0, 16'd0, 16'd1}, 7, 5'b01111));
    pins[2] = 0;
    mark = cyc;
    tick(10);
    // all-ones delay: counter saturates and the run still ends
    arm = 0;
    tick(2);
    delay = {8'd0, 8'd0, 8'd0, 8'd255};
    width = {8'd0, 8'd0, 8'd0, 8'd2};
    arm = 1;
    tick(2);
    push("t6_sat", run_rec(1, 256, {16'd0, 16'd0, 16'd0, 16'd255}, {N, N, N, 16'd255}, {16'd0, 16'd0, 16'd0, 16'd1}, 8, 5'b01111));
    fire_soft();
    tick(262);
    // reset in the middle of a run
    arm = 0;
    tick(2);
    delay = {8'd0, 8'd0, 8'd0, 8'd2};
    width = {8'd0, 8'd0, 8'd0, 8'd5};
    arm = 1;
    tick(2);
    push("t6_reset_run", run_rec(1, 4, {16'd0, 16'd0, 16'd0, 16'd2}, {N, N, N, 16'd2}, {16'd0, 16'd0, 16'd0, 16'd2}, 0, 5'b00000));
    fire_soft();
    tick(3);
    aresetn = 0;
    tick(1);
    probe_chk("t6_reset", 14'h0, 0);
    aresetn = 1;
    tick(5);
    while (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s never observed", name_q.pop_front());
      void'(exp_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
